// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer for exceptions, interrupts and MRET.
// Accepts one request in IDLE, writes mepc/mcause/mtval, then redirects the PC.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   exc_valid/code/pc/tval   synchronous exception request and its data
//   irq_pc                   PC of next instruction, becomes mepc on interrupts
//   mret                     MRET request
//   irq_en, mie, mip         global enable and interrupt enable/pending CSRs
//   mtvec, mepc              trap vector base/mode and return address CSRs
//   busy                     high whenever a sequence is in flight
//   redirect, redirect_pc    one-cycle PC redirect strobe and target
//   csr_addr/w/din           single CSR write port
//
// Build option: define TRAP_VECTORED_EN to vector interrupts when mtvec[1:0]==1.
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic [XLEN-1:0] irq_pc,
    input  logic            mret,
    input  logic            irq_en,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mip,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            busy,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [11:0]     csr_addr,
    output logic            csr_w,
    output logic [XLEN-1:0] csr_din
);

    typedef enum logic [2:0] {
        IDLE,
        WR_EPC,
        WR_CAUSE,
        WR_TVAL,
        REDIRECT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] target_q;

    logic            irq_hit;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] irq_target;
    logic            unused_bits;

    assign unused_bits = ^{mie, mip, mtvec};
    assign busy = (state != IDLE);
    assign base = {mtvec[XLEN-1:2], 2'b00};

    // Fixed priority among pending interrupts: MEI > MSI > MTI.
    always_comb begin
        irq_hit  = 1'b0;
        irq_code = 4'd0;
        if (irq_en && mie[11] && mip[11]) begin
            irq_hit  = 1'b1;
            irq_code = 4'd11;
        end else if (irq_en && mie[3] && mip[3]) begin
            irq_hit  = 1'b1;
            irq_code = 4'd3;
        end else if (irq_en && mie[7] && mip[7]) begin
            irq_hit  = 1'b1;
            irq_code = 4'd7;
        end
    end

`ifdef TRAP_VECTORED_EN
    logic [XLEN-1:0] vec_off;
    assign vec_off = {{(XLEN-6){1'b0}}, irq_code, 2'b00};
    // Sum wraps naturally at XLEN bits.
    assign irq_target = (mtvec[1:0] == 2'b01) ? base + vec_off : base;
`else
    assign irq_target = base;
`endif

    // Outputs are registered alongside the state they belong to, so each
    // transition loads the values the destination state presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cause_q     <= '0;
            tval_q      <= '0;
            target_q    <= '0;
            csr_w       <= 1'b0;
            csr_addr    <= '0;
            csr_din     <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            csr_w       <= 1'b0;
            csr_addr    <= '0;
            csr_din     <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            unique case (state)
                IDLE: begin
                    if (exc_valid) begin
                        cause_q  <= {1'b0, {(XLEN-5){1'b0}}, exc_code};
                        tval_q   <= exc_tval;
                        target_q <= base;
                        state    <= WR_EPC;
                        csr_w    <= 1'b1;
                        csr_addr <= 12'h341;
                        csr_din  <= {exc_pc[XLEN-1:1], 1'b0};
                    end else if (irq_hit) begin
                        cause_q  <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                        tval_q   <= '0;
                        target_q <= irq_target;
                        state    <= WR_EPC;
                        csr_w    <= 1'b1;
                        csr_addr <= 12'h341;
                        csr_din  <= {irq_pc[XLEN-1:1], 1'b0};
                    end else if (mret) begin
                        target_q    <= mepc;
                        state       <= REDIRECT;
                        redirect    <= 1'b1;
                        redirect_pc <= mepc;
                    end
                end
                WR_EPC: begin
                    state    <= WR_CAUSE;
                    csr_w    <= 1'b1;
                    csr_addr <= 12'h342;
                    csr_din  <= cause_q;
                end
                WR_CAUSE: begin
                    state    <= WR_TVAL;
                    csr_w    <= 1'b1;
                    csr_addr <= 12'h343;
                    csr_din  <= tval_q;
                end
                WR_TVAL: begin
                    state       <= REDIRECT;
                    redirect    <= 1'b1;
                    redirect_pc <= target_q;
                end
                REDIRECT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_trap_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            exc_valid = 1'b0;
    logic [3:0]      exc_code = '0;
    logic [XLEN-1:0] exc_pc = '0;
    logic [XLEN-1:0] exc_tval = '0;
    logic [XLEN-1:0] irq_pc = '0;
    logic            mret = 1'b0;
    logic            irq_en = 1'b0;
    logic [XLEN-1:0] mie = '0;
    logic [XLEN-1:0] mip = '0;
    logic [XLEN-1:0] mtvec = '0;
    logic [XLEN-1:0] mepc = '0;
    logic            busy;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [11:0]     csr_addr;
    logic            csr_w;
    logic [XLEN-1:0] csr_din;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk),
        .rst(rst),
        .exc_valid(exc_valid),
        .exc_code(exc_code),
        .exc_pc(exc_pc),
        .exc_tval(exc_tval),
        .irq_pc(irq_pc),
        .mret(mret),
        .irq_en(irq_en),
        .mie(mie),
        .mip(mip),
        .mtvec(mtvec),
        .mepc(mepc),
        .busy(busy),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .csr_addr(csr_addr),
        .csr_w(csr_w),
        .csr_din(csr_din)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic w, input logic [11:0] a,
                       input logic [31:0] d, input logic rd,
                       input logic [31:0] rpc, input logic bz);
        check({tag, ".busy"}, 32'(busy), 32'(bz));
        check({tag, ".csr_w"}, 32'(csr_w), 32'(w));
        check({tag, ".csr_addr"}, 32'(csr_addr), 32'(a));
        check({tag, ".csr_din"}, csr_din, d);
        check({tag, ".redirect"}, 32'(redirect), 32'(rd));
        check({tag, ".redirect_pc"}, redirect_pc, rpc);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Request must already be applied; the next posedge is the accept edge.
    task automatic run_trap(input string tag, input logic [31:0] e,
                            input logic [31:0] c, input logic [31:0] t,
                            input logic [31:0] tgt);
        tick();
        cyc({tag, ".epc"}, 1'b1, 12'h341, e, 1'b0, 32'h0, 1'b1);
        tick();
        cyc({tag, ".cause"}, 1'b1, 12'h342, c, 1'b0, 32'h0, 1'b1);
        tick();
        cyc({tag, ".tval"}, 1'b1, 12'h343, t, 1'b0, 32'h0, 1'b1);
        tick();
        cyc({tag, ".redir"}, 1'b0, 12'h0, 32'h0, 1'b1, tgt, 1'b1);
    endtask

    logic [31:0] exp_mei;
    logic [31:0] exp_msi;

    initial begin
`ifdef TRAP_VECTORED_EN
        exp_mei = 32'h0000_022C;
        exp_msi = 32'h0000_0008;
`else
        exp_mei = 32'h0000_0200;
        exp_msi = 32'hFFFF_FFFC;
`endif
        tick();
        tick();
        idle("reset");
        rst = 1'b0;
        tick();
        idle("post_reset");

        // Basic exception
        exc_valid = 1'b1;
        exc_code = 4'd2;
        exc_pc = 32'h104;
        exc_tval = 32'hDEAD;
        mtvec = 32'h200;
        run_trap("exc", 32'h104, 32'h2, 32'hDEAD, 32'h200);
        exc_valid = 1'b0;
        tick();
        idle("exc_done");

        // Exception with odd PC and vectored mode: still direct, bit 0 cleared
        exc_valid = 1'b1;
        exc_code = 4'd4;
        exc_pc = 32'h301;
        exc_tval = 32'h55;
        mtvec = 32'h201;
        run_trap("exc_vec", 32'h300, 32'h4, 32'h55, 32'h200);
        exc_valid = 1'b0;
        tick();
        idle("exc_vec_done");

        // Machine external interrupt
        irq_en = 1'b1;
        mie = 32'h888;
        mip = 32'h888;
        irq_pc = 32'h40;
        mtvec = 32'h201;
        run_trap("mei", 32'h40, 32'h8000_000B, 32'h0, exp_mei);
        irq_en = 1'b0;
        tick();
        idle("mei_done");

        // Software interrupt beats timer; vector target wraps
        irq_en = 1'b1;
        mip = 32'h088;
        irq_pc = 32'h7C;
        mtvec = 32'hFFFF_FFFD;
        run_trap("msi", 32'h7C, 32'h8000_0003, 32'h0, exp_msi);
        irq_en = 1'b0;
        tick();
        idle("msi_done");

        // Exception and timer together: exception first, then timer
        irq_en = 1'b1;
        mie = 32'h080;
        mip = 32'h080;
        irq_pc = 32'h90;
        mtvec = 32'h100;
        exc_valid = 1'b1;
        exc_code = 4'd5;
        exc_pc = 32'h80;
        exc_tval = 32'h11;
        run_trap("both_exc", 32'h80, 32'h5, 32'h11, 32'h100);
        exc_valid = 1'b0;
        tick();
        idle("both_gap");
        run_trap("both_mti", 32'h90, 32'h8000_0007, 32'h0, 32'h100);
        irq_en = 1'b0;
        tick();
        idle("both_done");

        // MRET
        mepc = 32'h1234;
        mret = 1'b1;
        tick();
        cyc("mret", 1'b0, 12'h0, 32'h0, 1'b1, 32'h1234, 1'b1);
        mret = 1'b0;
        tick();
        idle("mret_done");

        // Reset during WR_CAUSE
        exc_valid = 1'b1;
        exc_code = 4'd1;
        exc_pc = 32'h500;
        exc_tval = 32'h9;
        mtvec = 32'h200;
        tick();
        cyc("rst_epc", 1'b1, 12'h341, 32'h500, 1'b0, 32'h0, 1'b1);
        tick();
        cyc("rst_cause", 1'b1, 12'h342, 32'h1, 1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        exc_valid = 1'b0;
        tick();
        idle("rst_abort");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle("rst_quiet");
        end

        // Interrupts pending but globally disabled
        irq_en = 1'b0;
        mie = 32'h888;
        mip = 32'h888;
        for (int i = 0; i < 5; i++) begin
            tick();
            idle("irq_off");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
